// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with rename tags, broadcast snooping and tag-table checkpoints
module regfile_rename #(
    parameter int REG_S   = 32,
    parameter int DAT_W   = 32,
    parameter int ROB_BIT = 5,
    parameter int NBYP    = 2,
    parameter int CKPT_N  = 4,
    localparam int RB = $clog2(REG_S),
    localparam int CB = $clog2(CKPT_N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dsp_vld,
    output logic                    dsp_rdy,
    input  logic [RB-1:0]           dsp_rs1,
    input  logic [RB-1:0]           dsp_rs2,
    input  logic [RB-1:0]           dsp_rd,
    input  logic                    dsp_wr,
    input  logic [ROB_BIT-1:0]      dsp_tag,
    input  logic                    dsp_ckpt,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [ROB_BIT-1:0]      out_qj,
    output logic [ROB_BIT-1:0]      out_qk,
    output logic [DAT_W-1:0]        out_vj,
    output logic [DAT_W-1:0]        out_vk,
    output logic [ROB_BIT-1:0]      out_qd,
    output logic [CB-1:0]           out_ckpt,
    input  logic                    cmt_en,
    input  logic [RB-1:0]           cmt_rd,
    input  logic [ROB_BIT-1:0]      cmt_tag,
    input  logic [DAT_W-1:0]        cmt_v,
    input  logic [NBYP-1:0]         byp_en,
    input  logic [NBYP*ROB_BIT-1:0] byp_tag,
    input  logic [NBYP*DAT_W-1:0]   byp_v,
    input  logic                    rec_en,
    input  logic [CB-1:0]           rec_id,
    input  logic [CKPT_N-1:0]       rec_free,
    input  logic                    rel_en,
    input  logic [CB-1:0]           rel_id,
    input  logic                    flush_all
);
    logic [DAT_W-1:0]         regs [REG_S];
    logic [ROB_BIT-1:0]       tags [REG_S];
    logic [ROB_BIT-1:0]       tag_nxt [REG_S];
    logic [ROB_BIT-1:0]       ck [CKPT_N][REG_S];
    logic [CKPT_N-1:0]        ck_vld, ck_vld_nxt;
    logic                     free_any, accept;
    logic [CB-1:0]            free_id;
    logic [ROB_BIT+DAT_W-1:0] op_j, op_k;
    logic [DAT_W:0]           hold_j, hold_k;

    // {hit, value} for a pending tag; lowest broadcast channel wins, commit is the fallback
    function automatic logic [DAT_W:0] snoop(input logic [ROB_BIT-1:0] t);
        logic [DAT_W:0] r;
        r = (cmt_en && cmt_tag == t) ? {1'b1, cmt_v} : '0;
        for (int i = NBYP - 1; i >= 0; i--)
            if (byp_en[i] && byp_tag[i*ROB_BIT +: ROB_BIT] == t) r = {1'b1, byp_v[i*DAT_W +: DAT_W]};
        return r;
    endfunction

    // {tag, value} of a source operand, resolving a pending producer against this cycle's broadcasts
    function automatic logic [ROB_BIT+DAT_W-1:0] read_op(input logic [RB-1:0] rs);
        logic [ROB_BIT-1:0] t;
        logic [DAT_W:0]     s;
        t = tags[rs];
        s = snoop(t);
        if (rs == '0) return '0;
        if (t == '0) return {t, regs[rs]};
        return s[DAT_W] ? {{ROB_BIT{1'b0}}, s[DAT_W-1:0]} : {t, {DAT_W{1'b0}}};
    endfunction

    assign op_j    = read_op(dsp_rs1);
    assign op_k    = read_op(dsp_rs2);
    assign hold_j  = snoop(out_qj);
    assign hold_k  = snoop(out_qk);
    assign dsp_rdy = (!out_vld || out_rdy) && !rec_en && !flush_all && (!dsp_ckpt || free_any);
    assign accept  = dsp_vld && dsp_rdy;

    // lowest-index free checkpoint slot
    always_comb begin
        free_any = 1'b0;
        free_id  = '0;
        for (int i = CKPT_N - 1; i >= 0; i--)
            if (!ck_vld[i]) begin
                free_any = 1'b1;
                free_id  = CB'(i);
            end
    end

    // live tag table after commit clearing, with a same-cycle rename taking precedence
    always_comb begin
        for (int i = 0; i < REG_S; i++)
            tag_nxt[i] = (cmt_en && cmt_rd == RB'(i) && tags[i] == cmt_tag) ? '0 : tags[i];
        if (accept && dsp_wr && dsp_rd != '0) tag_nxt[dsp_rd] = dsp_tag;
    end

    // checkpoint occupancy: recovery/release free slots, a new checkpoint claims one
    always_comb begin
        ck_vld_nxt = ck_vld & ~(rec_en ? rec_free : '0);
        if (rel_en) ck_vld_nxt[rel_id] = 1'b0;
        if (accept && dsp_ckpt) ck_vld_nxt[free_id] = 1'b1;
        if (flush_all) ck_vld_nxt = '0;
    end

    // checkpoint storage: commits retire tags in every snapshot, new snapshots capture the updated table
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ck_vld <= '0;
            for (int c = 0; c < CKPT_N; c++)
                for (int i = 0; i < REG_S; i++) ck[c][i] <= '0;
        end else begin
            ck_vld <= ck_vld_nxt;
            for (int c = 0; c < CKPT_N; c++)
                for (int i = 0; i < REG_S; i++)
                    if (cmt_en && cmt_rd == RB'(i) && ck[c][i] == cmt_tag) ck[c][i] <= '0;
            if (accept && dsp_ckpt)
                for (int i = 0; i < REG_S; i++) ck[free_id][i] <= tag_nxt[i];
        end
    end

    // live tag table: flush clears, recovery restores a snapshot, otherwise normal update
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_all) begin
            for (int i = 0; i < REG_S; i++) tags[i] <= '0;
        end else if (rec_en) begin
            for (int i = 0; i < REG_S; i++)
                tags[i] <= (cmt_en && cmt_rd == RB'(i) && ck[rec_id][i] == cmt_tag) ? '0 : ck[rec_id][i];
        end else begin
            for (int i = 0; i < REG_S; i++) tags[i] <= tag_nxt[i];
        end
    end

    // committed values; register 0 stays zero and commits proceed even during flush/recovery
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_S; i++) regs[i] <= '0;
        end else if (cmt_en && cmt_rd != '0) begin
            regs[cmt_rd] <= cmt_v;
        end
    end

    // issue packet register: load on accept, drop on handshake, snoop broadcasts while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_qj   <= '0;
            out_qk   <= '0;
            out_vj   <= '0;
            out_vk   <= '0;
            out_qd   <= '0;
            out_ckpt <= '0;
        end else if (flush_all || rec_en) begin
            out_vld <= 1'b0;
        end else if (accept) begin
            out_vld          <= 1'b1;
            {out_qj, out_vj} <= op_j;
            {out_qk, out_vk} <= op_k;
            out_qd           <= dsp_tag;
            out_ckpt         <= dsp_ckpt ? free_id : '0;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end else if (out_vld) begin
            if (out_qj != '0 && hold_j[DAT_W]) begin
                out_qj <= '0;
                out_vj <= hold_j[DAT_W-1:0];
            end
            if (out_qk != '0 && hold_k[DAT_W]) begin
                out_qk <= '0;
                out_vk <= hold_k[DAT_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_regfile_rename.sv
// tb_regfile_rename: randomized scoreboard bench for regfile_rename against a tag-table reference model
module tb_regfile_rename;
    localparam int NB = 2;
    localparam int CN = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        dsp_vld, dsp_rdy, dsp_wr, dsp_ckpt;
    logic [4:0]  dsp_rs1, dsp_rs2, dsp_rd, dsp_tag;
    logic        out_vld, out_rdy;
    logic [4:0]  out_qj, out_qk, out_qd;
    logic [31:0] out_vj, out_vk;
    logic [1:0]  out_ckpt;
    logic        cmt_en;
    logic [4:0]  cmt_rd, cmt_tag;
    logic [31:0] cmt_v;
    logic [1:0]  byp_en;
    logic [9:0]  byp_tag;
    logic [63:0] byp_v;
    logic        rec_en, rel_en, flush_all;
    logic [1:0]  rec_id, rel_id;
    logic [3:0]  rec_free;

    always #5 clk = ~clk;

    regfile_rename dut (
        .clk(clk), .rst(rst), .dsp_vld(dsp_vld), .dsp_rdy(dsp_rdy), .dsp_rs1(dsp_rs1),
        .dsp_rs2(dsp_rs2), .dsp_rd(dsp_rd), .dsp_wr(dsp_wr), .dsp_tag(dsp_tag), .dsp_ckpt(dsp_ckpt),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_qj(out_qj), .out_qk(out_qk), .out_vj(out_vj),
        .out_vk(out_vk), .out_qd(out_qd), .out_ckpt(out_ckpt), .cmt_en(cmt_en), .cmt_rd(cmt_rd),
        .cmt_tag(cmt_tag), .cmt_v(cmt_v), .byp_en(byp_en), .byp_tag(byp_tag), .byp_v(byp_v),
        .rec_en(rec_en), .rec_id(rec_id), .rec_free(rec_free), .rel_en(rel_en), .rel_id(rel_id),
        .flush_all(flush_all)
    );

    typedef struct {
        logic [4:0]  qj, qk, qd;
        logic [31:0] vj, vk;
        logic [1:0]  ck;
        bit          has_ck;
    } pkt_t;

    pkt_t        sbq[$];
    logic [31:0] rv [32];
    logic [4:0]  rt [32];
    logic [4:0]  rck [4][32];
    bit          ckv [4];
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // value broadcast for a pending tag this cycle: channel 0 first, then 1, then commit
    function automatic logic [32:0] bcast(input logic [4:0] t);
        if (t == 0) return '0;
        for (int c = 0; c < NB; c++)
            if (byp_en[c] && byp_tag[c*5 +: 5] == t) return {1'b1, byp_v[c*32 +: 32]};
        if (cmt_en && cmt_tag == t) return {1'b1, cmt_v};
        return '0;
    endfunction

    task automatic rd_op(input logic [4:0] rs, output logic [4:0] q, output logic [31:0] v);
        logic [32:0] b;
        q = (rs == 0) ? 5'd0 : rt[rs];
        v = (rs == 0) ? 32'd0 : rv[rs];
        if (q != 0) begin
            b = bcast(q);
            if (b[32]) begin
                q = 0;
                v = b[31:0];
            end else v = 0;
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 32; i++) begin
            rv[i] = 0;
            rt[i] = 0;
            for (int c = 0; c < CN; c++) rck[c][i] = 0;
        end
        for (int c = 0; c < CN; c++) ckv[c] = 0;
        sbq.delete();
    endtask

    task automatic idle();
        dsp_vld = 0; dsp_rs1 = 0; dsp_rs2 = 0; dsp_rd = 0; dsp_wr = 0; dsp_tag = 1; dsp_ckpt = 0;
        out_rdy = 1; cmt_en = 0; cmt_rd = 0; cmt_tag = 0; cmt_v = 0;
        byp_en = 0; byp_tag = 0; byp_v = 0;
        rec_en = 0; rec_id = 0; rec_free = 0; rel_en = 0; rel_id = 0; flush_all = 0;
    endtask

    // one cycle of the reference model, evaluated on the inputs driven at this negedge
    task automatic step();
        pkt_t        p;
        logic [32:0] b;
        int          fid;
        bit          er, acc;
        #2;
        fid = -1;
        for (int c = CN - 1; c >= 0; c--) if (!ckv[c]) fid = c;
        er = sbq.size() == 0 && !rec_en && !flush_all && (!dsp_ckpt || fid >= 0);
        chk("dsp_rdy", dsp_rdy, er);
        acc = dsp_vld && er;
        if (acc) begin
            rd_op(dsp_rs1, p.qj, p.vj);
            rd_op(dsp_rs2, p.qk, p.vk);
            p.qd = dsp_tag;
            p.has_ck = dsp_ckpt;
            p.ck = dsp_ckpt ? 2'(fid) : 2'd0;
        end
        if (cmt_en && cmt_rd != 0) rv[cmt_rd] = cmt_v;
        if (flush_all) begin
            for (int i = 0; i < 32; i++) rt[i] = 0;
            for (int c = 0; c < CN; c++) ckv[c] = 0;
            sbq.delete();
        end else begin
            if (cmt_en)
                for (int c = 0; c < CN; c++) if (rck[c][cmt_rd] == cmt_tag) rck[c][cmt_rd] = 0;
            if (rec_en) begin
                for (int i = 0; i < 32; i++) rt[i] = rck[rec_id][i];
                for (int c = 0; c < CN; c++) if (rec_free[c]) ckv[c] = 0;
                sbq.delete();
            end else begin
                if (cmt_en && rt[cmt_rd] == cmt_tag) rt[cmt_rd] = 0;
                if (acc && dsp_wr && dsp_rd != 0) rt[dsp_rd] = dsp_tag;
            end
            if (rel_en) ckv[rel_id] = 0;
            if (acc && dsp_ckpt) begin
                for (int i = 0; i < 32; i++) rck[fid][i] = rt[i];
                ckv[fid] = 1;
            end
            if (acc) sbq.push_back(p);
            else if (sbq.size() != 0 && !rec_en) begin
                p = sbq[0];
                b = bcast(p.qj);
                if (b[32]) begin p.qj = 0; p.vj = b[31:0]; end
                b = bcast(p.qk);
                if (b[32]) begin p.qk = 0; p.vk = b[31:0]; end
                sbq[0] = p;
            end
        end
    endtask

    task automatic rand_in();
        int s;
        dsp_vld  = $urandom_range(0, 9) < 7;
        dsp_rd   = 5'($urandom);
        dsp_rs1  = $urandom_range(0, 3) == 0 ? dsp_rd : 5'($urandom);
        dsp_rs2  = 5'($urandom);
        dsp_wr   = $urandom_range(0, 4) != 0;
        dsp_tag  = 5'($urandom_range(1, 31));
        dsp_ckpt = $urandom_range(0, 4) == 0;
        out_rdy  = $urandom_range(0, 9) < 7;
        cmt_en   = $urandom_range(0, 9) < 4;
        cmt_rd   = 5'($urandom);
        cmt_tag  = $urandom_range(0, 3) != 0 ? rt[cmt_rd] : 5'($urandom);
        cmt_v    = $urandom;
        for (int c = 0; c < NB; c++) begin
            byp_en[c] = $urandom_range(0, 9) < 4;
            byp_tag[c*5 +: 5] = $urandom_range(0, 1) ? rt[5'($urandom)] : 5'($urandom);
            byp_v[c*32 +: 32] = $urandom;
        end
        rec_en = 0; rec_id = 0; rec_free = 0;
        if ($urandom_range(0, 19) == 0) begin
            s = $urandom_range(0, 3);
            for (int c = 0; c < CN; c++)
                if (!rec_en && ckv[(s + c) % CN]) begin
                    rec_en = 1;
                    rec_id = 2'((s + c) % CN);
                end
            rec_free = 4'($urandom);
        end
        rel_en    = $urandom_range(0, 6) == 0;
        rel_id    = 2'($urandom);
        flush_all = $urandom_range(0, 99) == 0;
    endtask

    task automatic disp(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic wr, input logic [4:0] tag, input logic ckpt);
        dsp_vld = 1; dsp_rs1 = rs1; dsp_rs2 = rs2; dsp_rd = rd; dsp_wr = wr; dsp_tag = tag; dsp_ckpt = ckpt;
    endtask

    // monitor: compares the presented packet with the scoreboard head, pops on handshake
    always @(negedge clk) begin
        pkt_t p;
        #1;
        if (!rst) begin
            chk("out_vld", out_vld, sbq.size() != 0);
            if (sbq.size() != 0) begin
                p = sbq[0];
                if (out_vld) begin
                    chk("out_qj", out_qj, p.qj);
                    chk("out_qk", out_qk, p.qk);
                    chk("out_qd", out_qd, p.qd);
                    if (p.qj == 0) chk("out_vj", out_vj, p.vj);
                    if (p.qk == 0) chk("out_vk", out_vk, p.vk);
                    if (p.has_ck) chk("out_ckpt", out_ckpt, p.ck);
                end
                if (out_rdy) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        idle();
        reset_model();
        #1;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_qj", out_qj, 0);
        chk("rst_out_qk", out_qk, 0);
        chk("rst_out_vj", out_vj, 0);
        chk("rst_out_vk", out_vk, 0);
        chk("rst_out_qd", out_qd, 0);
        chk("rst_out_ckpt", out_ckpt, 0);
        @(negedge clk); rst = 0; idle(); step();
        @(negedge clk); idle(); cmt_en = 1; cmt_rd = 5; cmt_v = 32'h11; step();
        // rename, pending read, same-cycle broadcast resolution
        @(negedge clk); idle(); disp(0, 0, 5, 1, 3, 0); step();
        @(negedge clk); idle(); disp(5, 0, 0, 0, 4, 0); step();
        @(negedge clk); idle(); disp(5, 5, 0, 0, 4, 0); byp_en = 2'b01; byp_tag = 10'd3; byp_v = 64'hAB; step();
        // commit of old producer racing a new rename of the same register
        @(negedge clk); idle(); disp(5, 0, 5, 1, 7, 0); cmt_en = 1; cmt_rd = 5; cmt_tag = 3; cmt_v = 9; step();
        @(negedge clk); idle(); disp(5, 5, 0, 0, 2, 0); step();
        @(negedge clk); idle(); cmt_en = 1; cmt_rd = 5; cmt_tag = 7; cmt_v = 32'h77; step();
        @(negedge clk); idle(); disp(5, 0, 0, 0, 2, 0); step();
        // stalled packet picks up a broadcast, dispatch held off
        @(negedge clk); idle(); disp(0, 0, 9, 1, 4, 0); step();
        @(negedge clk); idle(); disp(0, 9, 0, 0, 5, 0); step();
        @(negedge clk); idle(); out_rdy = 0; step();
        @(negedge clk); idle(); out_rdy = 0; disp(1, 2, 0, 0, 6, 0); byp_en = 2'b10; byp_tag = {5'd4, 5'd0};
        byp_v = {32'h55, 32'h0}; step();
        @(negedge clk); idle(); step();
        // checkpoint then recovery, without and with an intervening commit
        @(negedge clk); idle(); disp(0, 0, 6, 1, 2, 0); step();
        @(negedge clk); idle(); disp(0, 0, 0, 0, 10, 1); step();
        @(negedge clk); idle(); disp(0, 0, 6, 1, 8, 0); step();
        @(negedge clk); idle(); rec_en = 1; rec_id = 0; rec_free = 4'b0001; step();
        @(negedge clk); idle(); disp(6, 0, 0, 0, 11, 1); step();
        @(negedge clk); idle(); disp(0, 0, 6, 1, 8, 0); cmt_en = 1; cmt_rd = 6; cmt_tag = 2; cmt_v = 32'h66; step();
        @(negedge clk); idle(); rec_en = 1; rec_id = 0; rec_free = 4'b0001; step();
        @(negedge clk); idle(); disp(6, 0, 0, 0, 12, 0); step();
        // fill all checkpoints, refuse one more, release slot 2 and reuse it
        for (int i = 0; i < CN; i++) begin
            @(negedge clk); idle(); disp(0, 0, 5'(i + 1), 1, 5'(i + 13), 1); step();
        end
        @(negedge clk); idle(); disp(0, 0, 0, 0, 20, 1); step();
        @(negedge clk); idle(); disp(1, 2, 0, 0, 21, 0); step();
        @(negedge clk); idle(); rel_en = 1; rel_id = 2; step();
        @(negedge clk); idle(); disp(0, 0, 0, 0, 22, 1); step();
        @(negedge clk); idle(); flush_all = 1; step();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); rand_in(); step();
        end
        // asynchronous reset in the middle of a stall
        @(negedge clk); idle(); disp(0, 0, 10, 1, 6, 0); cmt_en = 1; cmt_rd = 10; cmt_v = 32'hC0; step();
        @(negedge clk); idle(); disp(10, 0, 0, 0, 7, 0); step();
        @(negedge clk); idle(); out_rdy = 0; step();
        @(negedge clk); #3; rst = 1; #1;
        chk("mid_rst_out_vld", out_vld, 0);
        chk("mid_rst_out_qj", out_qj, 0);
        chk("mid_rst_out_vj", out_vj, 0);
        reset_model();
        @(negedge clk); rst = 0; idle(); disp(10, 5, 0, 0, 3, 0); step();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk); idle(); step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
